// File: rtl/shift_add_pkg.sv
// Shared types for the shift-add multiplier controller.
// Holds the controller state encoding and the iteration-counter width helper.
// Optional build macro used by the controller: SHIFT_ADD_EARLY_EXIT_EN.
package shift_add_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TEST,
    ADD,
    SHIFT,
    DONE
  } state_t;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shift_add_ctrl_counter.sv
// Loadable up/down counter with saturation at both ends.
// load has priority over en; counts only when en is high.
// c_end flags that the next enabled step reaches the terminal value (0 down, all-ones up).
module shift_add_ctrl_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic         up_down,
  input  logic [N-1:0] data_in,
  output logic [N-1:0] cnt,
  output logic         c_end
);

  // Load, then saturating count in the selected direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= data_in;
    end else if (en) begin
      if (up_down) begin
        if (cnt != '1) cnt <= cnt + N'(1);
      end else begin
        if (cnt != '0) cnt <= cnt - N'(1);
      end
    end
  end

  // Terminal-count lookahead for the current direction.
  always_comb begin
    c_end = 1'b0;
    if (up_down) c_end = (cnt == ~N'(1));
    else         c_end = (cnt == N'(1));
  end

endmodule

// File: rtl/shift_add_ctrl.sv
// Moore sequencer for a shift-add multiplier: LOAD, then per bit TEST/(ADD)/SHIFT, then DONE.
// LOAD..DONE takes 2 + 2*N + popcount(B) cycles; done is a one-cycle pulse.
// Accepts start only in IDLE (start_ready); SHIFT_ADD_EARLY_EXIT_EN finishes as soon as B == 0.
module shift_add_ctrl
  import shift_add_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic          q_lsb,
  input  logic          q_zero,
  output logic          ld_regs,
  output logic          add_en,
  output logic          shift_en,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt
);

  state_t state;
  state_t next_state;
  logic   last_iter;

`ifndef SHIFT_ADD_EARLY_EXIT_EN
  // All N iterations always run, so the zero flag has no consumer here.
  logic unused_q_zero;
  assign unused_q_zero = q_zero;
`endif

  // Iterations remaining: loaded with N in LOAD, decremented once per SHIFT.
  shift_add_ctrl_counter #(
    .N(CW)
  ) u_iter_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (state == LOAD),
    .en      (state == SHIFT),
    .up_down (1'b0),
    .data_in (CW'(N)),
    .cnt     (cnt),
    .c_end   (last_iter)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    next_state  = state;
    start_ready = 1'b0;
    ld_regs     = 1'b0;
    add_en      = 1'b0;
    shift_en    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) next_state = LOAD;
      end
      LOAD: begin
        ld_regs    = 1'b1;
        next_state = TEST;
      end
      TEST: begin
`ifdef SHIFT_ADD_EARLY_EXIT_EN
        // Multiplicand already shifted into place, so P is final once B is empty.
        if (q_zero)     next_state = DONE;
        else if (q_lsb) next_state = ADD;
        else            next_state = SHIFT;
`else
        if (q_lsb) next_state = ADD;
        else       next_state = SHIFT;
`endif
      end
      ADD: begin
        add_en     = 1'b1;
        next_state = SHIFT;
      end
      SHIFT: begin
        shift_en   = 1'b1;
        next_state = last_iter ? DONE : TEST;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_add_ctrl.sv
// Bench for shift_add_ctrl driving a behavioural shift-add datapath.
// Stimulus pushes expected results; a negedge monitor pops and checks at each done.
// Directed vectors with hand-computed products, latencies and strobe counts.
module tb_shift_add_ctrl;

  localparam int N  = 4;
  localparam int CW = 3;

  typedef struct {
    logic [2*N-1:0] p;
    int             cyc;
    int             adds;
    int             shifts;
    int             cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_valid;
  logic          start_ready;
  logic          q_lsb;
  logic          q_zero;
  logic          ld_regs;
  logic          add_en;
  logic          shift_en;
  logic          busy;
  logic          done;
  logic [CW-1:0] cnt;

  logic [N-1:0]   a_in;
  logic [N-1:0]   b_in;
  logic [2*N-1:0] dp_a;
  logic [N-1:0]   dp_b;
  logic [2*N-1:0] dp_p;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_total = 0;

  always #5 clk = ~clk;

  shift_add_ctrl #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .q_lsb       (q_lsb),
    .q_zero      (q_zero),
    .ld_regs     (ld_regs),
    .add_en      (add_en),
    .shift_en    (shift_en),
    .busy        (busy),
    .done        (done),
    .cnt         (cnt)
  );

  // Behavioural datapath: left-shift multiplicand, right-shift multiplier.
  always @(posedge clk) begin
    if (ld_regs) begin
      dp_a <= {{N{1'b0}}, a_in};
      dp_b <= b_in;
      dp_p <= '0;
    end else begin
      if (add_en) dp_p <= dp_p + dp_a;
      if (shift_en) begin
        dp_a <= dp_a << 1;
        dp_b <= dp_b >> 1;
      end
    end
  end
  assign q_lsb  = dp_b[0];
  assign q_zero = (dp_b == '0);

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int p, input int cyc, input int adds, input int shifts, input int c);
    exp_t e;
    e.p = p[2*N-1:0];
    e.cyc = cyc;
    e.adds = adds;
    e.shifts = shifts;
    e.cnt = c;
    return e;
  endfunction

  // Monitor: per-cycle strobe exclusivity, per-operation accounting, scoreboard pop at done.
  int  mon_cyc = 0, mon_adds = 0, mon_shifts = 0;
  bit  in_op = 0;
  bit  prev_done = 0;
  always @(negedge clk) begin
    if (rst) begin
      in_op = 0;
      prev_done = 0;
    end else begin
      chk("strobe_overlap", int'(ld_regs) + int'(add_en) + int'(shift_en) <= 1, 1);
      if (ld_regs) begin
        in_op = 1; mon_cyc = 1; mon_adds = 0; mon_shifts = 0;
      end else if (in_op) begin
        mon_cyc++;
      end
      if (add_en) mon_adds++;
      if (shift_en) mon_shifts++;
      if (done) begin
        exp_t e;
        done_total++;
        chk("done_single_cycle", prev_done, 0);
        chk("done_start_ready", start_ready, 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("product", dp_p, e.p);
          chk("latency", mon_cyc, e.cyc);
          chk("add_pulses", mon_adds, e.adds);
          chk("shift_pulses", mon_shifts, e.shifts);
          chk("cnt_at_done", cnt, e.cnt);
        end
        in_op = 0;
      end
      prev_done = done;
    end
  end

  // Drive one start; returns at the negedge of the LOAD cycle with start_valid dropped.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input exp_t e, input bit expect_done);
    @(negedge clk);
    a_in = a;
    b_in = b;
    start_valid = 1'b1;
    if (expect_done) sb.push_back(e);
    for (int i = 0; i < 50 && !start_ready; i++) @(negedge clk);
    if (!start_ready) chk("accept_timeout", 0, 1);
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  // Returns at the negedge where done is high, or flags a timeout.
  task automatic wait_done();
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    if (!done) chk("done_timeout", 0, 1);
  endtask

  exp_t e_b0, e_b5;
  int   done_snap;

  initial begin
    rst = 1'b1;
    start_valid = 1'b0;
    a_in = '0;
    b_in = '0;
`ifdef SHIFT_ADD_EARLY_EXIT_EN
    e_b0 = mk(0, 3, 0, 0, 4);
    e_b5 = mk(30, 11, 2, 3, 1);
`else
    e_b0 = mk(0, 10, 0, 4, 0);
    e_b5 = mk(30, 12, 2, 4, 0);
`endif
    #12;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_strobes", {ld_regs, add_en, shift_en, done}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle with start_valid low.
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_ld", ld_regs, 0);

    // Main vectors: 13*11, 9*0, 15*15, 6*5, 7*8.
    start_op(4'd13, 4'b1011, mk(143, 13, 3, 4, 0), 1); wait_done(); @(negedge clk);
    start_op(4'd9,  4'b0000, e_b0, 1);                 wait_done(); @(negedge clk);
    start_op(4'd15, 4'b1111, mk(225, 14, 4, 4, 0), 1); wait_done(); @(negedge clk);
    start_op(4'd6,  4'b0101, e_b5, 1);                 wait_done(); @(negedge clk);
    start_op(4'd7,  4'b1000, mk(56, 11, 1, 4, 0), 1);  wait_done(); @(negedge clk);

    // start_valid held high: one acceptance per operation, next one only from IDLE.
    @(negedge clk);
    a_in = 4'd13;
    b_in = 4'b1011;
    start_valid = 1'b1;
    sb.push_back(mk(143, 13, 3, 4, 0));
    sb.push_back(mk(143, 13, 3, 4, 0));
    @(negedge clk);
    chk("hold_first_ld", ld_regs, 1);
    wait_done();
    @(negedge clk);
    chk("after_done_ready", start_ready, 1);
    chk("after_done_busy", busy, 0);
    @(negedge clk);
    chk("reaccept_ld", ld_regs, 1);
    wait_done();
    start_valid = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("hold_end_idle", busy, 0);

    // Reset during the second ADD: no done, then a clean restart.
    start_op(4'd13, 4'b1011, mk(0, 0, 0, 0, 0), 0);
    done_snap = done_total;
    begin
      int seen = 0;
      for (int i = 0; i < 50 && seen < 2; i++) begin
        if (add_en) seen++;
        if (seen < 2) @(negedge clk);
      end
      chk("abort_reached_add2", seen, 2);
    end
    rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", start_ready, 1);
    chk("async_rst_cnt", cnt, 0);
    chk("async_rst_strobes", {ld_regs, add_en, shift_en, done}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_total, done_snap);
    start_op(4'd11, 4'b1101, mk(143, 13, 3, 4, 0), 1); wait_done(); @(negedge clk);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
